// File: rtl/ieeedrv_trkload.sv
// Track loader for the IEEE drive emulation: computes the 256-byte block address of a
// track, writes back a dirty buffer and reads the requested track over an SD handshake.
module ieeedrv_trkload #(
    parameter int SUBDRV = 2
) (
    input  logic                                              clk_sys,
    input  logic                                              reset_n,
    input  logic                                              drv_type,
    input  logic                                              loaded,
    input  logic [((SUBDRV > 1) ? $clog2(SUBDRV) : 1)-1:0]    drv_act,
    input  logic [7:0]                                        track,
    input  logic                                              flush,
    input  logic                                              dirty_set,
    output logic                                              busy,
    output logic                                              error,
    output logic [4:0]                                        sec_cnt,
    output logic [31:0]                                       sd_lba,
    output logic                                              sd_rd,
    output logic                                              sd_wr,
    input  logic                                              sd_ack,
    output logic [4:0]                                        buf_sec,
    output logic [((SUBDRV > 1) ? $clog2(SUBDRV) : 1)-1:0]    img_sel
);

    localparam int DW = (SUBDRV > 1) ? $clog2(SUBDRV) : 1;

    typedef enum logic [2:0] {IDLE, CALC, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, READY, BAD} state_t;

    state_t        state;
    logic [7:0]    cur_trk;
    logic [DW-1:0] cur_drv;
    logic [7:0]    idx;
    logic [15:0]   acc;
    logic [15:0]   base;
    logic          dirty;
    logic          wb_calc;
    logic          trk_chg;
    logic          trk_ok;
    logic [31:0]   lba_next;

    function automatic logic [4:0] spt(input logic [7:0] t, input logic g4040);
        logic [7:0] u;
        logic [4:0] r;
        if (g4040) begin
            if (t <= 8'd17)      r = 5'd21;
            else if (t <= 8'd24) r = 5'd19;
            else if (t <= 8'd30) r = 5'd18;
            else                 r = 5'd17;
        end else begin
            // the second half of an 8250 image repeats the 8050 zone layout
            u = (t > 8'd77) ? t - 8'd77 : t;
            if (u <= 8'd39)      r = 5'd29;
            else if (u <= 8'd53) r = 5'd27;
            else if (u <= 8'd64) r = 5'd25;
            else                 r = 5'd23;
        end
        return r;
    endfunction

    function automatic logic is_valid(input logic [7:0] t, input logic g4040);
        return (t != 8'd0) && (g4040 ? (t <= 8'd35) : (t <= 8'd154));
    endfunction

    assign trk_chg  = (track != cur_trk) || (drv_act != cur_drv);
    assign trk_ok   = is_valid(track, drv_type);
    assign lba_next = {16'd0, base} + {27'd0, buf_sec} + 32'd1;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            busy    <= 1'b1;
            error   <= 1'b0;
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            sd_lba  <= '0;
            buf_sec <= '0;
            sec_cnt <= '0;
            img_sel <= '0;
            dirty   <= 1'b0;
            wb_calc <= 1'b0;
            cur_trk <= '0;
            cur_drv <= '0;
            idx     <= '0;
            acc     <= '0;
            base    <= '0;
        end else begin
            busy  <= 1'b1;
            error <= 1'b0;
            case (state)
                // a (re)mount always reloads, even when the track number is unchanged
                IDLE: begin
                    dirty <= 1'b0;
                    if (loaded) begin
                        cur_trk <= track;
                        cur_drv <= drv_act;
                        idx     <= 8'd1;
                        acc     <= '0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    if (!loaded) begin
                        state <= IDLE;
                    end else if (trk_chg) begin
                        cur_trk <= track;
                        cur_drv <= drv_act;
                        idx     <= 8'd1;
                        acc     <= '0;
                    end else if (!is_valid(cur_trk, drv_type)) begin
                        state <= BAD;
                        error <= 1'b1;
                    end else if (idx == cur_trk) begin
                        base    <= acc;
                        sec_cnt <= spt(cur_trk, drv_type) - 5'd1;
                        img_sel <= cur_drv;
                        buf_sec <= '0;
                        sd_lba  <= {16'd0, acc};
                        sd_rd   <= 1'b1;
                        state   <= RD_REQ;
                    end else begin
                        acc <= acc + {11'd0, spt(idx, drv_type)};
                        idx <= idx + 8'd1;
                    end
                end
                RD_REQ: begin
                    if (sd_ack) begin
                        sd_rd <= 1'b0;
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (!sd_ack) begin
                        if (!loaded) begin
                            state <= IDLE;
                            dirty <= 1'b0;
                        end else if (trk_chg) begin
                            cur_trk <= track;
                            cur_drv <= drv_act;
                            idx     <= 8'd1;
                            acc     <= '0;
                            state   <= CALC;
                        end else if (buf_sec == sec_cnt) begin
                            state <= READY;
                            busy  <= 1'b0;
                            dirty <= 1'b0;
                        end else begin
                            buf_sec <= buf_sec + 5'd1;
                            sd_lba  <= lba_next;
                            sd_rd   <= 1'b1;
                            state   <= RD_REQ;
                        end
                    end
                end
                WB_REQ: begin
                    if (sd_ack) begin
                        sd_wr <= 1'b0;
                        state <= WB_WAIT;
                    end
                end
                // track changes seen during write-back are picked up only once it finishes
                WB_WAIT: begin
                    if (!sd_ack) begin
                        if (!loaded) begin
                            state <= IDLE;
                            dirty <= 1'b0;
                        end else if (buf_sec == sec_cnt) begin
                            dirty <= 1'b0;
                            if (wb_calc || trk_chg) begin
                                cur_trk <= track;
                                cur_drv <= drv_act;
                                idx     <= 8'd1;
                                acc     <= '0;
                                state   <= CALC;
                            end else begin
                                state <= READY;
                                busy  <= 1'b0;
                            end
                        end else begin
                            buf_sec <= buf_sec + 5'd1;
                            sd_lba  <= lba_next;
                            sd_wr   <= 1'b1;
                            state   <= WB_REQ;
                        end
                    end
                end
                READY: begin
                    if (!loaded) begin
                        state <= IDLE;
                        dirty <= 1'b0;
                    end else if (trk_chg) begin
                        cur_trk <= track;
                        cur_drv <= drv_act;
                        if (dirty || dirty_set) begin
                            wb_calc <= 1'b1;
                            buf_sec <= '0;
                            sd_lba  <= {16'd0, base};
                            sd_wr   <= 1'b1;
                            state   <= WB_REQ;
                        end else begin
                            idx   <= 8'd1;
                            acc   <= '0;
                            state <= CALC;
                        end
                    end else if (flush && (dirty || dirty_set)) begin
                        wb_calc <= 1'b0;
                        buf_sec <= '0;
                        sd_lba  <= {16'd0, base};
                        sd_wr   <= 1'b1;
                        state   <= WB_REQ;
                    end else begin
                        busy <= 1'b0;
                        if (dirty_set) dirty <= 1'b1;
                    end
                end
                BAD: begin
                    if (!loaded) begin
                        state <= IDLE;
                    end else if (trk_chg && trk_ok) begin
                        cur_trk <= track;
                        cur_drv <= drv_act;
                        idx     <= 8'd1;
                        acc     <= '0;
                        state   <= CALC;
                    end else begin
                        error <= 1'b1;
                        if (trk_chg) begin
                            cur_trk <= track;
                            cur_drv <= drv_act;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ieeedrv_trkload.md
IEEEDRV_TRKLOAD -- requirements
Module: ieeedrv_trkload

Interface
REQ-001 SHALL have parameter SUBDRV, default 2, number of sub-drive image slots.
REQ-002 SHALL have port clk_sys  input  1  system clock; all sequential logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port drv_type  input  1  1=4040 geometry, 0=8050/8250 geometry.
REQ-005 SHALL have ports loaded  input  1  image mounted; drv_act  input  $clog2(SUBDRV)  active sub-drive; track  input  8  requested track, 1-based.
REQ-006 SHALL have ports flush  input  1  write-back request pulse; dirty_set  input  1  buffer-write pulse from track generator.
REQ-007 SHALL have ports busy  output  1  track buffer not valid; error  output  1  invalid track; sec_cnt  output  5  sectors in track minus one.
REQ-008 SHALL have ports sd_lba  output  32  256-byte block address; sd_rd  output  1; sd_wr  output  1; sd_ack  input  1; buf_sec  output  5  buffer sector index for upper buffer address bits; img_sel  output  $clog2(SUBDRV)  image slot.

Function
REQ-009 SHALL use states IDLE, CALC, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, READY, BAD.
REQ-010 SHALL compute sectors per track: 4040: tracks 1-17 21, 18-24 19, 25-30 18, 31-35 17; 8050: 1-39 29, 40-53 27, 54-64 25, 65-77 23, then 78-116, 117-130, 131-141, 142-154 repeating 29/27/25/23.
REQ-011 SHALL treat track 0, track>35 (4040) or track>154 (8050) as invalid -> BAD.
REQ-012 SHALL compute track base in CALC iteratively, one preceding track per cycle, base = sum of sector counts of tracks 1..track-1, 16-bit accumulator, zero-extended to sd_lba.
REQ-013 SHALL, on IDLE/READY with loaded=1 and (track or drv_act differs from latched value), latch new track/drv_act and enter CALC; in READY with dirty=1, first perform write-back of the old track.
REQ-014 SHALL in CALC completion enter RD_REQ with buf_sec=0.
REQ-015 SHALL drive sd_lba = base + buf_sec, sd_rd=1 in RD_REQ (sd_wr=1 in WB_REQ), holding it until sd_ack=1, then deassert and go to *_WAIT.
REQ-016 SHALL treat sd_ack falling edge in *_WAIT as sector complete; if buf_sec==sec_cnt go to next phase, else buf_sec+1 and back to *_REQ.
REQ-017 SHALL after read phase enter READY, busy=0, dirty=0; after write phase clear dirty, go to CALC for new track (or READY if flush-only).
REQ-018 SHALL set dirty on dirty_set only in READY; dirty_set in other states ignored.
REQ-019 SHALL on flush pulse in READY with dirty=1 run write-back of current track, then return to READY; flush with dirty=0 ignored.
REQ-020 SHALL, on track/drv_act change during a transfer, complete the current sector handshake, then restart at CALC; a started write-back completes fully first.
REQ-021 SHALL on loaded=0 abort to IDLE at the next handshake boundary (never while sd_ack=1), discard dirty, busy=1.
REQ-022 SHALL assert busy=1 in every state except READY; error=1 only in BAD; BAD exits to CALC on any valid track change.
REQ-023 SHALL never assert sd_rd and sd_wr together.

Reset
REQ-024 SHALL asynchronously on reset_n=0 set state IDLE, busy=1, error=0, sd_rd=0, sd_wr=0, sd_lba=0, buf_sec=0, sec_cnt=0, img_sel=0, dirty=0, latched track=0.
REQ-025 SHALL abandon any handshake on reset; first action after release is CALC from IDLE if loaded=1.

Verification
REQ-026 4040, track=1, loaded=1 -> 21 reads at lba 0..20, then busy=0, sec_cnt=20.
REQ-027 4040, track=18 -> base 357, 19 reads lba 357..375, sec_cnt=18.
REQ-028 8050, track=40 READY, dirty_set, then track=41 -> 27 writes lba 1131..1157, then 27 reads lba 1158..1184.
REQ-029 track=0 or 4040 track=36 -> error=1, busy=1, no sd_rd/sd_wr; then track=5 -> error=0, reads from lba 84.
REQ-030 reset_n low while sd_ack=1 mid-read -> sd_rd=0, busy=1 immediately; after release, reload restarts at buf_sec=0.
